// File: rtl/cathode_mux.sv
// Registered 8:1 cathode pattern multiplexer for the 8-digit seven-segment display.
// One aclk of latency from digit_select / dig* to cathode; synchronous reset blanks the bus.
module cathode_mux #(
    parameter int                   NUM_DIGITS = 8,
    parameter int                   SEL_W      = 3,
    parameter int                   SEG_W      = 7,
    parameter logic [0:SEG_W-1]     BLANK_VAL  = 7'b1111111
) (
    input  logic                 aclk,
    input  logic                 reset,
    input  logic [0:SEL_W-1]     digit_select,
    input  logic [0:SEG_W-1]     dig0,
    input  logic [0:SEG_W-1]     dig1,
    input  logic [0:SEG_W-1]     dig2,
    input  logic [0:SEG_W-1]     dig3,
    input  logic [0:SEG_W-1]     dig4,
    input  logic [0:SEG_W-1]     dig5,
    input  logic [0:SEG_W-1]     dig6,
    input  logic [0:SEG_W-1]     dig7,
    output logic [0:SEG_W-1]     cathode
);

    logic [0:SEG_W-1] dig_bus [NUM_DIGITS];
    logic [0:SEG_W-1] next_pattern;

    always_comb begin
        dig_bus[0] = dig0;
        dig_bus[1] = dig1;
        dig_bus[2] = dig2;
        dig_bus[3] = dig3;
        dig_bus[4] = dig4;
        dig_bus[5] = dig5;
        dig_bus[6] = dig6;
        dig_bus[7] = dig7;
    end

    // Bit 0 of digit_select is the MSB, so the vector reads directly as the digit index.
    always_comb begin
        next_pattern = BLANK_VAL;
        case (digit_select)
            3'd0:    next_pattern = dig_bus[0];
            3'd1:    next_pattern = dig_bus[1];
            3'd2:    next_pattern = dig_bus[2];
            3'd3:    next_pattern = dig_bus[3];
            3'd4:    next_pattern = dig_bus[4];
            3'd5:    next_pattern = dig_bus[5];
            3'd6:    next_pattern = dig_bus[6];
            3'd7:    next_pattern = dig_bus[7];
            default: next_pattern = BLANK_VAL;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            cathode <= BLANK_VAL;
        end else begin
            cathode <= next_pattern;
        end
    end

endmodule

// File: tb/tb_cathode_mux.sv
// Directed self-checking bench for cathode_mux: reset, scan, latency, data hold, bit order.
module tb_cathode_mux;

    logic       aclk;
    logic       reset;
    logic [0:2] digit_select;
    logic [0:6] dig0, dig1, dig2, dig3, dig4, dig5, dig6, dig7;
    logic [0:6] cathode;
    logic [0:6] exp_val;
    logic [0:5] upper_bits;

    int errors;
    int checks;

    cathode_mux dut (
        .aclk         (aclk),
        .reset        (reset),
        .digit_select (digit_select),
        .dig0         (dig0),
        .dig1         (dig1),
        .dig2         (dig2),
        .dig3         (dig3),
        .dig4         (dig4),
        .dig5         (dig5),
        .dig6         (dig6),
        .dig7         (dig7),
        .cathode      (cathode)
    );

    initial aclk = 1'b0;
    always #50 aclk = ~aclk;

    task automatic load_index_patterns();
        dig0 = 7'd0; dig1 = 7'd1; dig2 = 7'd2; dig3 = 7'd3;
        dig4 = 7'd4; dig5 = 7'd5; dig6 = 7'd6; dig7 = 7'd7;
    endtask

    // Inputs change 1 ns after a rising edge; outputs are read at the same point.
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        load_index_patterns();
        digit_select = 3'd5;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (cathode !== 7'b1111111) begin
                errors++;
                $display("FAIL reset_edge%0d: cathode=%b expected=%b", i, cathode, 7'b1111111);
            end
        end
    endtask

    task automatic test_full_scan();
        reset = 1'b0;
        load_index_patterns();
        for (int i = 0; i < 9; i++) begin
            digit_select = 3'(i % 8);
            exp_val = 7'(i % 8);
            tick();
            checks++;
            if (cathode !== exp_val) begin
                errors++;
                $display("FAIL scan_step%0d: cathode=%h expected=%h", i, cathode, exp_val);
            end
        end
    endtask

    task automatic test_latency();
        dig3 = 7'h55;
        digit_select = 3'd3;
        #20;
        checks++;
        if (cathode !== 7'h00) begin
            errors++;
            $display("FAIL latency_hold_before3: cathode=%h expected=%h", cathode, 7'h00);
        end
        tick();
        checks++;
        if (cathode !== 7'h55) begin
            errors++;
            $display("FAIL latency_sel3: cathode=%h expected=%h", cathode, 7'h55);
        end
        dig6 = 7'h2A;
        digit_select = 3'd6;
        #20;
        checks++;
        if (cathode !== 7'h55) begin
            errors++;
            $display("FAIL latency_hold_before6: cathode=%h expected=%h", cathode, 7'h55);
        end
        tick();
        checks++;
        if (cathode !== 7'h2A) begin
            errors++;
            $display("FAIL latency_sel6: cathode=%h expected=%h", cathode, 7'h2A);
        end
    endtask

    task automatic test_data_change();
        digit_select = 3'd2;
        dig2 = 7'h7F;
        tick();
        checks++;
        if (cathode !== 7'h7F) begin
            errors++;
            $display("FAIL data_initial: cathode=%h expected=%h", cathode, 7'h7F);
        end
        #20;
        dig2 = 7'h00;
        #20;
        checks++;
        if (cathode !== 7'h7F) begin
            errors++;
            $display("FAIL data_midcycle: cathode=%h expected=%h", cathode, 7'h7F);
        end
        tick();
        checks++;
        if (cathode !== 7'h00) begin
            errors++;
            $display("FAIL data_next_edge: cathode=%h expected=%h", cathode, 7'h00);
        end
    endtask

    task automatic test_mid_reset();
        load_index_patterns();
        digit_select = 3'd3;
        tick();
        checks++;
        if (cathode !== 7'd3) begin
            errors++;
            $display("FAIL midrst_pre: cathode=%h expected=%h", cathode, 7'd3);
        end
        digit_select = 3'd4;
        reset = 1'b1;
        tick();
        checks++;
        if (cathode !== 7'b1111111) begin
            errors++;
            $display("FAIL midrst_blank: cathode=%b expected=%b", cathode, 7'b1111111);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (cathode !== 7'd4) begin
            errors++;
            $display("FAIL midrst_resume: cathode=%h expected=%h", cathode, 7'd4);
        end
        digit_select = 3'd5;
        tick();
        checks++;
        if (cathode !== 7'd5) begin
            errors++;
            $display("FAIL midrst_next: cathode=%h expected=%h", cathode, 7'd5);
        end
    endtask

    task automatic test_bit_order();
        dig1 = 7'b1000000;
        digit_select = 3'd1;
        tick();
        checks++;
        if (cathode[0] !== 1'b1) begin
            errors++;
            $display("FAIL bit0_set: cathode[0]=%b expected=1", cathode[0]);
        end
        upper_bits = cathode[1:6];
        checks++;
        if (upper_bits !== 6'b000000) begin
            errors++;
            $display("FAIL bits1to6_clear: cathode[1:6]=%b expected=000000", upper_bits);
        end
        dig7 = 7'b0000001;
        digit_select = 3'd7;
        tick();
        checks++;
        if (cathode !== 7'b0000001) begin
            errors++;
            $display("FAIL bit6_only: cathode=%b expected=%b", cathode, 7'b0000001);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b1;
        digit_select = 3'd0;
        load_index_patterns();
        test_reset();
        test_full_scan();
        test_latency();
        test_data_change();
        test_mid_reset();
        test_bit_order();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
